// File: rtl/edge_counter_pkg.sv
// Shared constants and edge-decode helper for the edge counter.
// EDGE_MODE selects which transitions of the event input count.
package edge_counter_pkg;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  function automatic logic edge_hit(input int mode, input logic cur, input logic prev);
    case (mode)
      EDGE_FALL: return ~cur & prev;
      EDGE_BOTH: return cur ^ prev;
      default:   return cur & ~prev;
    endcase
  endfunction

endpackage

// File: rtl/edge_counter_edge_detect.sv
// Edge detector: optional two-flop input synchronizer (EDGE_COUNTER_SYNC_EN),
// previous-level register, primed flag and edge decode. hit is combinational.
module edge_detect
  import edge_counter_pkg::*;
#(
  parameter int EDGE_MODE = EDGE_RISE
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic hit
);

  if (EDGE_MODE < EDGE_RISE || EDGE_MODE > EDGE_BOTH) begin : g_bad_mode
    $error("edge_detect: EDGE_MODE must be 0, 1 or 2");
  end

  logic sampled;
  logic in_prev;
  logic primed;

`ifdef EDGE_COUNTER_SYNC_EN
  logic sync_1;
  logic sync_2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= in;
      sync_2 <= sync_1;
    end
  end

  assign sampled = sync_2;
`else
  assign sampled = in;
`endif

  // primed stays low for the first clock after reset so a level already
  // present at release is not mistaken for a transition from the reset value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_prev <= 1'b0;
      primed  <= 1'b0;
    end else begin
      in_prev <= sampled;
      primed  <= 1'b1;
    end
  end

  assign hit = primed & edge_hit(EDGE_MODE, sampled, in_prev);

endmodule

// File: rtl/edge_counter.sv
// Modulo-CNT_MAX up/down edge counter with clear, clamped load and limit pulses.
// Define EDGE_COUNTER_SYNC_EN to synchronize the event input (latency 3 instead of 1).
module edge_counter
  import edge_counter_pkg::*;
#(
  parameter int WIDTH     = 5,
  parameter int CNT_MAX   = 24,
  parameter int EDGE_MODE = EDGE_RISE,
  parameter int SATURATE  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             en,
  input  logic             dir,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt,
  output logic             ovf,
  output logic             udf,
  output logic             edge_pulse
);

  if (CNT_MAX < 2 || CNT_MAX > 2**WIDTH) begin : g_bad_cnt_max
    $error("edge_counter: CNT_MAX must satisfy 2 <= CNT_MAX <= 2**WIDTH");
  end

  // CNT_MAX itself may need WIDTH+1 bits when it equals 2**WIDTH
  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(CNT_MAX);
  localparam logic [WIDTH-1:0] TOP     = WIDTH'(CNT_MAX - 1);

  logic hit;

  edge_detect #(
    .EDGE_MODE (EDGE_MODE)
  ) u_edge_detect (
    .clk (clk),
    .rst (rst),
    .in  (in),
    .hit (hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      ovf        <= 1'b0;
      udf        <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      edge_pulse <= hit;
      ovf        <= 1'b0;
      udf        <= 1'b0;
      if (clr) begin
        cnt <= '0;
      end else if (load) begin
        cnt <= ({1'b0, load_val} >= MAX_EXT) ? TOP : load_val;
      end else if (hit && en) begin
        if (!dir) begin
          if (cnt == TOP) begin
            ovf <= 1'b1;
            if (SATURATE != 0) cnt <= cnt;
            else               cnt <= '0;
          end else begin
            cnt <= cnt + WIDTH'(1);
          end
        end else begin
          if (cnt == '0) begin
            udf <= 1'b1;
            if (SATURATE != 0) cnt <= cnt;
            else               cnt <= TOP;
          end else begin
            cnt <= cnt - WIDTH'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_edge_counter.sv
// Self-checking bench: default, saturating and both-edge instances share stimulus;
// expected outputs are queued per step and compared one clock later.
module tb_edge_counter;
  import edge_counter_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in = 1'b0;
  logic       en = 1'b0;
  logic       dir = 1'b0;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [4:0] load_val = '0;

  logic [4:0] cnt_d, cnt_s, cnt_b;
  logic       ovf_d, ovf_s, ovf_b;
  logic       udf_d, udf_s, udf_b;
  logic       edge_d, edge_s, edge_b;

  always #5 clk = ~clk;

  edge_counter u_dut (
    .clk(clk), .rst(rst), .in(in), .en(en), .dir(dir), .clr(clr), .load(load),
    .load_val(load_val), .cnt(cnt_d), .ovf(ovf_d), .udf(udf_d), .edge_pulse(edge_d)
  );

  edge_counter #(.SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .in(in), .en(en), .dir(dir), .clr(clr), .load(load),
    .load_val(load_val), .cnt(cnt_s), .ovf(ovf_s), .udf(udf_s), .edge_pulse(edge_s)
  );

  edge_counter #(.EDGE_MODE(EDGE_BOTH)) u_both (
    .clk(clk), .rst(rst), .in(in), .en(en), .dir(dir), .clr(clr), .load(load),
    .load_val(load_val), .cnt(cnt_b), .ovf(ovf_b), .udf(udf_b), .edge_pulse(edge_b)
  );

  typedef struct packed {
    logic [4:0] cnt;
    logic       ovf;
    logic       udf;
    logic       edg;
  } obs_t;

  typedef struct {
    int   sel;
    obs_t v;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic obs_t observe(input int sel);
    case (sel)
      1:       return {cnt_s, ovf_s, udf_s, edge_s};
      2:       return {cnt_b, ovf_b, udf_b, edge_b};
      default: return {cnt_d, ovf_d, udf_d, edge_d};
    endcase
  endfunction

  task automatic push(input int sel, input logic [4:0] c, input logic o, input logic u, input logic e);
    exp_t x;
    x.sel = sel;
    x.v   = {c, o, u, e};
    sb.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 3; k++) push(k, 5'd0, 1'b0, 1'b0, 1'b0);
      case (s)
        0: begin rst = 1'b1; in = 1'b1; #1; end
        1: begin tick(); rst = 1'b0; tick(); end
        default: tick();
      endcase
      while (sb.size() != 0) begin
        exp_t x; obs_t o;
        x = sb.pop_front(); o = observe(x.sel); checks++;
        if (o !== x.v) begin
          errors++;
          $display("FAIL reset step=%0d sel=%0d got cnt=%0d ovf=%b udf=%b edge=%b want cnt=%0d ovf=%b udf=%b edge=%b",
                   s, x.sel, o.cnt, o.ovf, o.udf, o.edg, x.v.cnt, x.v.ovf, x.v.udf, x.v.edg);
        end
      end
    end
  endtask

  task automatic test_wrap();
    en = 1'b1; dir = 1'b0;
    for (int s = 0; s < 49; s++) begin
      int i;
      i = (s - 1) / 2;
      if (s == 0) begin
        in = 1'b0; clr = 1'b1;
        push(0, 5'd0, 1'b0, 1'b0, 1'b0);
        push(1, 5'd0, 1'b0, 1'b0, 1'b0);
      end else if ((s % 2) == 1) begin
        clr = 1'b0; in = 1'b1;
        push(0, 5'((i + 1) % 24), i == 23, 1'b0, 1'b1);
        push(1, (i == 23) ? 5'd23 : 5'(i + 1), i == 23, 1'b0, 1'b1);
      end else begin
        in = 1'b0;
        push(0, 5'((i + 1) % 24), 1'b0, 1'b0, 1'b0);
        push(1, (i == 23) ? 5'd23 : 5'(i + 1), 1'b0, 1'b0, 1'b0);
      end
      tick();
      while (sb.size() != 0) begin
        exp_t x; obs_t o;
        x = sb.pop_front(); o = observe(x.sel); checks++;
        if (o !== x.v) begin
          errors++;
          $display("FAIL wrap step=%0d sel=%0d got cnt=%0d ovf=%b udf=%b edge=%b want cnt=%0d ovf=%b udf=%b edge=%b",
                   s, x.sel, o.cnt, o.ovf, o.udf, o.edg, x.v.cnt, x.v.ovf, x.v.udf, x.v.edg);
        end
      end
    end
  endtask

  task automatic test_underflow();
    en = 1'b1;
    for (int s = 0; s < 5; s++) begin
      case (s)
        0: begin clr = 1'b1; dir = 1'b1; in = 1'b0;
             push(0, 5'd0, 1'b0, 1'b0, 1'b0); push(1, 5'd0, 1'b0, 1'b0, 1'b0); end
        1: begin clr = 1'b0; in = 1'b1;
             push(0, 5'd23, 1'b0, 1'b1, 1'b1); push(1, 5'd0, 1'b0, 1'b1, 1'b1); end
        2: begin in = 1'b0; dir = 1'b0;
             push(0, 5'd23, 1'b0, 1'b0, 1'b0); push(1, 5'd0, 1'b0, 1'b0, 1'b0); end
        3: begin dir = 1'b1; in = 1'b1;
             push(0, 5'd22, 1'b0, 1'b0, 1'b1); push(1, 5'd0, 1'b0, 1'b1, 1'b1); end
        default: begin in = 1'b0;
             push(0, 5'd22, 1'b0, 1'b0, 1'b0); push(1, 5'd0, 1'b0, 1'b0, 1'b0); end
      endcase
      tick();
      while (sb.size() != 0) begin
        exp_t x; obs_t o;
        x = sb.pop_front(); o = observe(x.sel); checks++;
        if (o !== x.v) begin
          errors++;
          $display("FAIL underflow step=%0d sel=%0d got cnt=%0d ovf=%b udf=%b edge=%b want cnt=%0d ovf=%b udf=%b edge=%b",
                   s, x.sel, o.cnt, o.ovf, o.udf, o.edg, x.v.cnt, x.v.ovf, x.v.udf, x.v.edg);
        end
      end
    end
    dir = 1'b0;
  endtask

  task automatic test_priority();
    en = 1'b1; dir = 1'b0;
    for (int s = 0; s < 8; s++) begin
      case (s)
        0: begin clr = 1'b1; load = 1'b1; load_val = 5'd30; in = 1'b1; push(0, 5'd0, 1'b0, 1'b0, 1'b1); end
        1: begin clr = 1'b0; push(0, 5'd23, 1'b0, 1'b0, 1'b0); end
        2: begin load_val = 5'd5; in = 1'b0; push(0, 5'd5, 1'b0, 1'b0, 1'b0); end
        3: begin load_val = 5'd24; in = 1'b1; push(0, 5'd23, 1'b0, 1'b0, 1'b1); end
        4: begin load = 1'b0; in = 1'b0; push(0, 5'd23, 1'b0, 1'b0, 1'b0); end
        5: begin load = 1'b1; load_val = 5'd22; push(0, 5'd22, 1'b0, 1'b0, 1'b0); end
        6: begin load = 1'b0; in = 1'b1; push(0, 5'd23, 1'b0, 1'b0, 1'b1); end
        default: begin in = 1'b0; push(0, 5'd23, 1'b0, 1'b0, 1'b0); end
      endcase
      tick();
      while (sb.size() != 0) begin
        exp_t x; obs_t o;
        x = sb.pop_front(); o = observe(x.sel); checks++;
        if (o !== x.v) begin
          errors++;
          $display("FAIL priority step=%0d sel=%0d got cnt=%0d ovf=%b udf=%b edge=%b want cnt=%0d ovf=%b udf=%b edge=%b",
                   s, x.sel, o.cnt, o.ovf, o.udf, o.edg, x.v.cnt, x.v.ovf, x.v.udf, x.v.edg);
        end
      end
    end
  endtask

  task automatic test_enable();
    dir = 1'b0;
    for (int s = 0; s < 8; s++) begin
      en = (s >= 5);
      in = (s < 5) ? ((s % 2) == 0) : 1'b1;
      push(0, 5'd23, 1'b0, 1'b0, (s < 5) && ((s % 2) == 0));
      tick();
      while (sb.size() != 0) begin
        exp_t x; obs_t o;
        x = sb.pop_front(); o = observe(x.sel); checks++;
        if (o !== x.v) begin
          errors++;
          $display("FAIL enable step=%0d sel=%0d got cnt=%0d ovf=%b udf=%b edge=%b want cnt=%0d ovf=%b udf=%b edge=%b",
                   s, x.sel, o.cnt, o.ovf, o.udf, o.edg, x.v.cnt, x.v.ovf, x.v.udf, x.v.edg);
        end
      end
    end
  endtask

  task automatic test_both_edges();
    en = 1'b1; dir = 1'b0;
    for (int s = 0; s < 8; s++) begin
      case (s)
        0: begin clr = 1'b1; push(2, 5'd0, 1'b0, 1'b0, 1'b0); end
        1, 2, 3, 4: begin clr = 1'b0; in = ~in; push(2, 5'(s), 1'b0, 1'b0, 1'b1); end
        5: push(2, 5'd4, 1'b0, 1'b0, 1'b0);
        6: begin dir = 1'b1; in = ~in; push(2, 5'd3, 1'b0, 1'b0, 1'b1); end
        default: begin dir = 1'b0; in = ~in; push(2, 5'd4, 1'b0, 1'b0, 1'b1); end
      endcase
      tick();
      while (sb.size() != 0) begin
        exp_t x; obs_t o;
        x = sb.pop_front(); o = observe(x.sel); checks++;
        if (o !== x.v) begin
          errors++;
          $display("FAIL both_edges step=%0d sel=%0d got cnt=%0d ovf=%b udf=%b edge=%b want cnt=%0d ovf=%b udf=%b edge=%b",
                   s, x.sel, o.cnt, o.ovf, o.udf, o.edg, x.v.cnt, x.v.ovf, x.v.udf, x.v.edg);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    en = 1'b1; dir = 1'b0;
    for (int s = 0; s < 6; s++) begin
      case (s)
        0: begin load = 1'b1; load_val = 5'd17; push(0, 5'd17, 1'b0, 1'b0, 1'b0); tick(); load = 1'b0; end
        1: begin in = 1'b0; push(0, 5'd17, 1'b0, 1'b0, 1'b0); tick(); end
        2: begin
             in = 1'b1;
             #3 rst = 1'b1;
             for (int k = 0; k < 3; k++) push(k, 5'd0, 1'b0, 1'b0, 1'b0);
             #1;
           end
        3: begin #2 rst = 1'b0; push(0, 5'd0, 1'b0, 1'b0, 1'b0); tick(); end
        4: begin in = 1'b0; push(0, 5'd0, 1'b0, 1'b0, 1'b0); tick(); end
        default: begin in = 1'b1; push(0, 5'd1, 1'b0, 1'b0, 1'b1); tick(); end
      endcase
      while (sb.size() != 0) begin
        exp_t x; obs_t o;
        x = sb.pop_front(); o = observe(x.sel); checks++;
        if (o !== x.v) begin
          errors++;
          $display("FAIL async_reset step=%0d sel=%0d got cnt=%0d ovf=%b udf=%b edge=%b want cnt=%0d ovf=%b udf=%b edge=%b",
                   s, x.sel, o.cnt, o.ovf, o.udf, o.edg, x.v.cnt, x.v.ovf, x.v.udf, x.v.edg);
        end
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_wrap();
    test_underflow();
    test_priority();
    test_enable();
    test_both_edges();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/edge_counter.md
EDGE_COUNTER -- requirements
Module: edge_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 5: counter width in bits.
REQ-002 SHALL have parameter CNT_MAX, default 24: modulus; count range 0..CNT_MAX-1.
REQ-003 SHALL have parameter EDGE_MODE, default 0: 0 rising, 1 falling, 2 both edges of in.
REQ-004 SHALL have parameter SATURATE, default 0: 0 wrap at limits, 1 hold at limits.
REQ-005 SHALL have port clk, input, 1: sole clock, all state on rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port in, input, 1: event input, clk-synchronous unless EDGE_COUNTER_SYNC_EN.
REQ-008 SHALL have port en, input, 1: count enable.
REQ-009 SHALL have port dir, input, 1: 0 count up, 1 count down.
REQ-010 SHALL have port clr, input, 1: synchronous clear.
REQ-011 SHALL have port load, input, 1: synchronous load strobe.
REQ-012 SHALL have port load_val, input, WIDTH: load value.
REQ-013 SHALL have port cnt, output, WIDTH: registered count.
REQ-014 SHALL have port ovf, output, 1: one-cycle pulse on up-limit event.
REQ-015 SHALL have port udf, output, 1: one-cycle pulse on down-limit event.
REQ-016 SHALL have port edge, output, 1: registered one-cycle pulse per detected edge, independent of en.

Function
REQ-017 SHALL register in into in_prev every cycle regardless of en, clr, load.
REQ-018 SHALL detect edge per EDGE_MODE by comparing current sampled in with in_prev.
REQ-019 SHALL suppress edge detection in the first clock after reset release (primed flag).
REQ-020 SHALL apply priority clr > load > count event (edge AND en) > hold each cycle.
REQ-021 SHALL on clr set cnt=0, no ovf/udf.
REQ-022 SHALL on load set cnt=load_val, clamped to CNT_MAX-1 if load_val >= CNT_MAX; no ovf/udf.
REQ-023 SHALL on up event: cnt<CNT_MAX-1 -> cnt+1; cnt==CNT_MAX-1 -> 0 (wrap) or hold (saturate), ovf=1 for one cycle.
REQ-024 SHALL on down event: cnt>0 -> cnt-1; cnt==0 -> CNT_MAX-1 (wrap) or hold (saturate), udf=1 for one cycle.
REQ-025 SHALL update cnt, ovf, udf, edge at the same clock edge that samples the new in level (latency 1 clock from in change).
REQ-026 SHALL deassert ovf, udf, edge in every cycle without a qualifying event; no pulse stretching.
REQ-027 SHALL ignore dir changes except at count events; dir sampled with the event.
REQ-028 SHALL be elaborated only for 2 <= CNT_MAX <= 2**WIDTH; otherwise elaboration error.

Reset
REQ-029 SHALL asynchronously on rst=1 set cnt=0, ovf=0, udf=0, edge=0, in_prev=0, primed=0 (and synchronizer flops 0).
REQ-030 SHALL, on rst mid-count, discard pending events; first count possible on second clock after release.

Configuration
REQ-031 SHALL, with EDGE_COUNTER_SYNC_EN defined, pass in through a two-flop synchronizer before edge detection; latency 3 clocks from in change.
REQ-032 SHALL, without EDGE_COUNTER_SYNC_EN, use in directly; latency per REQ-025.

Structure
REQ-033 SHALL place EDGE_MODE constants (EDGE_RISE, EDGE_FALL, EDGE_BOTH) in shared package edge_counter_pkg.
REQ-034 SHALL implement synchronizer, in_prev, primed flag and edge decode in sub-module edge_detect.

Verification
REQ-035 SHALL cover: defaults, 24 rising edges en=1 dir=0 -> cnt 0..23 then 0, ovf one pulse on 24th edge.
REQ-036 SHALL cover: cnt=0, dir=1, one edge -> cnt=23, udf pulse; SATURATE=1 -> cnt stays 0, udf pulse.
REQ-037 SHALL cover: clr, load(load_val=30) and edge same cycle -> cnt=0; then load only -> cnt=23.
REQ-038 SHALL cover: en=0 during 3 edges then en=1, in held high -> cnt unchanged, edge pulses 3 times, no spurious count.
REQ-039 SHALL cover: in=1 across reset release -> no edge, cnt=0; EDGE_MODE=2 toggling 4 times -> cnt=4.
REQ-040 SHALL cover: rst asserted between clocks at cnt=17 -> cnt=0, ovf=udf=0 immediately.
